// File: rtl/resp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : resp_arbiter_pkg
//  Description : Shared constants and types for the authentication responder
//                arbiter: one-hot FSM state encodings, message header field
//                sizes and the ERROR/BUSY response header contents.
//  Revision    : 1.0 - initial release
// ============================================================================
package resp_arbiter_pkg;

    localparam int c_size_of_states_arb       = 6;
    localparam int c_msg_len_def              = 64;
    localparam int c_size_of_header_vars      = 8;   // bits per header field
    localparam int c_size_of_header_in_bytes  = 4;

    localparam logic [7:0] c_protocol_version = 8'h01;
    localparam logic [7:0] c_err_msg_type     = 8'h7F;
    localparam logic [7:0] c_err_code_busy    = 8'h03;

    typedef enum logic [c_size_of_states_arb-1:0] {
        ARB_IDLE     = 6'b000001,
        ARB_GRANT    = 6'b000010,
        ARB_ISSUE    = 6'b000100,
        ARB_WAIT_RSP = 6'b001000,
        ARB_DELIVER  = 6'b010000,
        ARB_RELEASE  = 6'b100000
    } arb_state_t;

    // Header byte 0 sits in the least significant byte of a message:
    // {Param2, Param1, MessageType, ProtocolVersion}.
    function automatic logic [c_size_of_header_in_bytes*c_size_of_header_vars-1:0] err_header();
        return {8'h00, c_err_code_busy, c_err_msg_type, c_protocol_version};
    endfunction

endpackage
`default_nettype wire

// File: rtl/resp_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Picks the lowest request
//                index at or after rr_ptr, wrapping past NUM_REQ-1 to 0.
//  Ports       : req       - request vector
//                rr_ptr    - search start index (always < NUM_REQ)
//                grant_idx - winning index (0 when grant_any is low)
//                grant_any - at least one request is pending
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    // Walk the offsets from the far end back toward rr_ptr so the last hit
    // written is the nearest one at or after the pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant_any = 1'b1;
                grant_idx = c_idx_w'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/resp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : resp_arbiter
//  Description : Shares one authentication responder among NUM_REQ requesters.
//                Grants one request at a time (round-robin), runs the
//                responder req/msg/ack handshake, and returns the captured
//                response to the granted requester.
//  Ports       : clk, reset (sync, active-high)
//                req_valid/req_msg/req_ack   - requester side, request path
//                rsp_valid/rsp_msg/rsp_ack   - requester side, response path
//                resp_req/resp_msg/resp_ack  - to responder
//                resp_done/resp_rsp_msg      - from responder
//  Config      : RESP_ARB_TIMEOUT_EN - when defined, a saturating counter in
//                WAIT_RSP synthesizes an ERROR/BUSY response after
//                TIMEOUT_CYCLES; otherwise WAIT_RSP waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_arbiter
    import resp_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MSG_LEN        = c_msg_len_def,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*MSG_LEN-1:0] req_msg,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [MSG_LEN-1:0]         rsp_msg,
    input  logic [NUM_REQ-1:0]         rsp_ack,
    output logic                       resp_req,
    output logic [MSG_LEN-1:0]         resp_msg,
    output logic                       resp_ack,
    input  logic                       resp_done,
    input  logic [MSG_LEN-1:0]         resp_rsp_msg
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    arb_state_t            r_state, w_state_nx;
    logic [c_idx_w-1:0]    r_grant, w_grant_nx;
    logic [c_idx_w-1:0]    r_rr_ptr, w_rr_ptr_nx;
    logic [MSG_LEN-1:0]    r_msg_q, w_msg_q_nx;
    logic [MSG_LEN-1:0]    r_rsp_q, w_rsp_q_nx;
    logic [NUM_REQ-1:0]    r_req_ack, w_req_ack_nx;
    logic [NUM_REQ-1:0]    r_rsp_valid, w_rsp_valid_nx;
    logic [MSG_LEN-1:0]    r_rsp_msg, w_rsp_msg_nx;
    logic                  r_resp_req, w_resp_req_nx;
    logic [MSG_LEN-1:0]    r_resp_msg, w_resp_msg_nx;
    logic                  r_resp_ack, w_resp_ack_nx;

    logic [c_idx_w-1:0]    w_grant_idx;
    logic                  w_grant_any;
    logic                  w_timeout;
    logic [MSG_LEN-1:0]    w_err_msg;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

`ifdef RESP_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Cleared on issue, counts only while waiting, and parks at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ARB_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == ARB_WAIT_RSP && r_cnt != c_cnt_w'(TIMEOUT_CYCLES)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ARB_WAIT_RSP) && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES));
    assign w_err_msg = MSG_LEN'(err_header());
`else
    assign w_timeout = 1'b0;
    assign w_err_msg = '0;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_grant_nx     = r_grant;
        w_rr_ptr_nx    = r_rr_ptr;
        w_msg_q_nx     = r_msg_q;
        w_rsp_q_nx     = r_rsp_q;
        w_req_ack_nx   = '0;
        w_rsp_valid_nx = r_rsp_valid;
        w_rsp_msg_nx   = r_rsp_msg;
        w_resp_req_nx  = r_resp_req;
        w_resp_msg_nx  = r_resp_msg;
        w_resp_ack_nx  = 1'b0;

        unique case (r_state)
            ARB_IDLE: begin
                if (|req_valid) w_state_nx = ARB_GRANT;
            end
            ARB_GRANT: begin
                // Requesters hold req_valid until acked, so a vanished
                // request can only follow a glitch; fall back to IDLE.
                if (w_grant_any) begin
                    w_grant_nx                = w_grant_idx;
                    w_msg_q_nx                = req_msg[int'(w_grant_idx)*MSG_LEN +: MSG_LEN];
                    w_req_ack_nx[w_grant_idx] = 1'b1;
                    w_state_nx                = ARB_ISSUE;
                end else begin
                    w_state_nx = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                w_resp_req_nx = 1'b1;
                w_resp_msg_nx = r_msg_q;
                w_state_nx    = ARB_WAIT_RSP;
            end
            ARB_WAIT_RSP: begin
                // A real answer takes priority over a coincident timeout.
                if (resp_done) begin
                    w_rsp_q_nx    = resp_rsp_msg;
                    w_resp_ack_nx = 1'b1;
                    w_resp_req_nx = 1'b0;
                    w_state_nx    = ARB_DELIVER;
                end else if (w_timeout) begin
                    w_rsp_q_nx    = w_err_msg;
                    w_resp_req_nx = 1'b0;
                    w_state_nx    = ARB_DELIVER;
                end
            end
            ARB_DELIVER: begin
                w_rsp_valid_nx          = '0;
                w_rsp_valid_nx[r_grant] = 1'b1;
                w_rsp_msg_nx            = r_rsp_q;
                // Only an ack for a response the requester can already see.
                if (r_rsp_valid[r_grant] && rsp_ack[r_grant]) w_state_nx = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                w_rsp_valid_nx = '0;
                w_rr_ptr_nx    = (r_grant == c_idx_w'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                w_state_nx     = ARB_IDLE;
            end
            default: begin
                w_state_nx = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_msg_q     <= '0;
            r_rsp_q     <= '0;
            r_req_ack   <= '0;
            r_rsp_valid <= '0;
            r_rsp_msg   <= '0;
            r_resp_req  <= 1'b0;
            r_resp_msg  <= '0;
            r_resp_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_grant     <= w_grant_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_msg_q     <= w_msg_q_nx;
            r_rsp_q     <= w_rsp_q_nx;
            r_req_ack   <= w_req_ack_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_msg   <= w_rsp_msg_nx;
            r_resp_req  <= w_resp_req_nx;
            r_resp_msg  <= w_resp_msg_nx;
            r_resp_ack  <= w_resp_ack_nx;
        end
    end

    assign req_ack   = r_req_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_msg   = r_rsp_msg;
    assign resp_req  = r_resp_req;
    assign resp_msg  = r_resp_msg;
    assign resp_ack  = r_resp_ack;

endmodule
`default_nettype wire

// File: tb/tb_resp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resp_arbiter
//  Description : Self-checking bench for resp_arbiter (NUM_REQ=4, MSG_LEN=64,
//                TIMEOUT_CYCLES=16). Timeout scenarios are built only when
//                RESP_ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_arbiter;

    localparam int NR = 4;
    localparam int ML = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_ack, rsp_valid, rsp_ack;
    logic [NR*ML-1:0] req_msg;
    logic [ML-1:0]   rsp_msg, resp_msg, resp_rsp_msg;
    logic            resp_req, resp_ack, resp_done;

    int n_tests = 0;
    int n_fail  = 0;

    int            q_grant[$];
    logic [ML-1:0] q_rsp[$];

    resp_arbiter #(
        .NUM_REQ        (NR),
        .MSG_LEN        (ML),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_msg      (req_msg),
        .req_ack      (req_ack),
        .rsp_valid    (rsp_valid),
        .rsp_msg      (rsp_msg),
        .rsp_ack      (rsp_ack),
        .resp_req     (resp_req),
        .resp_msg     (resp_msg),
        .resp_ack     (resp_ack),
        .resp_done    (resp_done),
        .resp_rsp_msg (resp_rsp_msg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One full transaction for the granted requester popped from q_grant.
    task automatic run_txn(input int delay, input bit drop, input bit stray, input logic [ML-1:0] data);
        int            g;
        int            waited;
        logic [ML-1:0] exp_msg;
        logic [ML-1:0] exp_rsp;
        logic [NR-1:0] onehot;
        g      = q_grant.pop_front();
        onehot = NR'(1) << g;
        waited = 0;
        while (req_ack === '0 && waited < 20) begin
            tick();
            waited++;
        end
        n_tests++;
        if (req_ack !== onehot) begin
            n_fail++;
            $display("FAIL grant: req_ack=%b, required %b", req_ack, onehot);
        end
        exp_msg = req_msg[g*ML +: ML];
        if (drop) begin
            req_valid[g]         = 1'b0;
            req_msg[g*ML +: ML]  = ~exp_msg;
        end
        tick();
        n_tests++;
        if (req_ack !== '0 || resp_req !== 1'b1 || resp_msg !== exp_msg) begin
            n_fail++;
            $display("FAIL issue: req_ack=%b resp_req=%b resp_msg=%h, required 0000/1/%h",
                     req_ack, resp_req, resp_msg, exp_msg);
        end
        repeat (delay) tick();
        resp_done    = 1'b1;
        resp_rsp_msg = data;
        q_rsp.push_back(data);
        tick();
        resp_done    = 1'b0;
        resp_rsp_msg = {$urandom, $urandom};
        n_tests++;
        if (resp_ack !== 1'b1 || resp_req !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_ack: resp_ack=%b resp_req=%b, required 1/0", resp_ack, resp_req);
        end
        tick();
        exp_rsp = q_rsp.pop_front();
        n_tests++;
        if (rsp_valid !== onehot || rsp_msg !== exp_rsp || resp_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL deliver: rsp_valid=%b rsp_msg=%h resp_ack=%b, required %b/%h/0",
                     rsp_valid, rsp_msg, resp_ack, onehot, exp_rsp);
        end
        if (stray) begin
            rsp_ack = (g == 1) ? 4'b0001 : 4'b0010;
            tick();
            rsp_ack = '0;
            tick();
            n_tests++;
            if (rsp_valid !== onehot || rsp_msg !== exp_rsp) begin
                n_fail++;
                $display("FAIL stray_ack: rsp_valid=%b rsp_msg=%h, required %b/%h",
                         rsp_valid, rsp_msg, onehot, exp_rsp);
            end
        end
        rsp_ack[g] = 1'b1;
        tick();
        rsp_ack = '0;
        n_tests++;
        if (rsp_valid !== onehot) begin
            n_fail++;
            $display("FAIL ack_edge: rsp_valid=%b, required %b", rsp_valid, onehot);
        end
        tick();
        n_tests++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL release: rsp_valid=%b, required 0000", rsp_valid);
        end
        if (drop) req_msg[g*ML +: ML] = exp_msg;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if ({req_ack, rsp_valid, rsp_msg, resp_req, resp_msg, resp_ack} !== '0) begin
            n_fail++;
            $display("FAIL reset: req_ack=%b rsp_valid=%b rsp_msg=%h resp_req=%b resp_msg=%h resp_ack=%b, required all 0",
                     req_ack, rsp_valid, rsp_msg, resp_req, resp_msg, resp_ack);
        end
    endtask

    task automatic test_stray_done_idle();
        resp_done    = 1'b1;
        resp_rsp_msg = 64'hDEAD_BEEF_0000_1111;
        tick();
        resp_done = 1'b0;
        tick();
        n_tests++;
        if ({req_ack, rsp_valid, resp_req, resp_ack} !== '0) begin
            n_fail++;
            $display("FAIL stray_done: req_ack=%b rsp_valid=%b resp_req=%b resp_ack=%b, required all 0",
                     req_ack, rsp_valid, resp_req, resp_ack);
        end
    endtask

    task automatic test_single();
        req_msg[2*ML +: ML] = 64'h0000_0000_0000_8101;   // GET_DIGESTS
        req_valid = 4'b0100;
        q_grant.push_back(2);
        run_txn(0, 1'b1, 1'b1, 64'h0000_0000_0000_0101);
    endtask

    task automatic test_reset_in_wait();
        int waited;
        do_reset();
        req_valid = 4'b0001;
        q_grant.push_back(0);
        run_txn(1, 1'b1, 1'b0, 64'h1111_2222_3333_4444);
        req_valid = 4'b0100;
        waited = 0;
        while (req_ack === '0 && waited < 20) begin
            tick();
            waited++;
        end
        req_valid = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({req_ack, rsp_valid, rsp_msg, resp_req, resp_msg, resp_ack} !== '0) begin
            n_fail++;
            $display("FAIL reset_wait: req_ack=%b rsp_valid=%b resp_req=%b resp_ack=%b, required all 0",
                     req_ack, rsp_valid, resp_req, resp_ack);
        end
        repeat (4) tick();
        n_tests++;
        if (rsp_valid !== '0 || resp_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon: rsp_valid=%b resp_req=%b, required 0000/0", rsp_valid, resp_req);
        end
        req_valid = 4'b0011;
        q_grant.push_back(0);
        q_grant.push_back(1);
        run_txn(0, 1'b1, 1'b0, 64'hAAAA_0000_0000_0001);
        run_txn(2, 1'b1, 1'b0, 64'hBBBB_0000_0000_0002);
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 4'b1111;
        q_grant.push_back(0);
        q_grant.push_back(1);
        q_grant.push_back(2);
        q_grant.push_back(3);
        q_grant.push_back(0);
        for (int i = 0; i < 5; i++) begin
            run_txn(i % 3, 1'b0, 1'b0, {32'hC0DE_0000, 32'(i)});
        end
        req_valid = 4'b0000;
        tick();
        tick();
        n_tests++;
        if (req_ack !== '0 || resp_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_idle: req_ack=%b resp_req=%b, required 0000/0", req_ack, resp_req);
        end
    endtask

`ifdef RESP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int            waited;
        int            cnt;
        bit            saw_ack;
        logic [ML-1:0] err_exp;
        err_exp = 64'h0000_0000_0003_7F01;
        do_reset();
        req_valid = 4'b0010;
        waited = 0;
        while (req_ack === '0 && waited < 20) begin
            tick();
            waited++;
        end
        n_tests++;
        if (req_ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL to_grant: req_ack=%b, required 0010", req_ack);
        end
        req_valid = 4'b0000;
        tick();
        cnt     = 0;
        saw_ack = 1'b0;
        while (resp_req === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            if (resp_ack !== 1'b0) saw_ack = 1'b1;
        end
        n_tests++;
        if (cnt !== 17) begin
            n_fail++;
            $display("FAIL to_latency: resp_req dropped after %0d edges, required 17", cnt);
        end
        tick();
        if (resp_ack !== 1'b0) saw_ack = 1'b1;
        n_tests++;
        if (saw_ack) begin
            n_fail++;
            $display("FAIL to_no_ack: resp_ack pulsed=1, required 0");
        end
        n_tests++;
        if (rsp_valid !== 4'b0010 || rsp_msg !== err_exp) begin
            n_fail++;
            $display("FAIL to_err: rsp_valid=%b rsp_msg=%h, required 0010/%h", rsp_valid, rsp_msg, err_exp);
        end
        rsp_ack = 4'b0010;
        tick();
        rsp_ack = '0;
        tick();
        n_tests++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL to_release: rsp_valid=%b, required 0000", rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        req_valid = 4'b0100;
        q_grant.push_back(2);
        run_txn(16, 1'b1, 1'b0, 64'h5151_6262_7373_8484);
    endtask
`endif

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        rsp_ack      = '0;
        resp_done    = 1'b0;
        resp_rsp_msg = '0;
        for (int i = 0; i < NR; i++) begin
            req_msg[i*ML +: ML] = {32'h5EED_0000, 24'h0, 8'(8'h10 + i)};
        end
        test_reset();
        test_stray_done_idle();
        test_single();
        test_reset_in_wait();
        test_fairness();
`ifdef RESP_ARB_TIMEOUT_EN
        test_timeout();
        test_simultaneous();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/resp_arbiter.md
# resp_arbiter

Shares the single authentication responder between `NUM_REQ` independent requesters, such as multiple Type-C port policy engines. It grants one request message at a time using round-robin and drives the responder's request/message/ack handshake. It captures the response, returns it to the granted requester, and synthesizes an ERROR response if the responder does not answer in time. It sits between the per-port message layers and `responder`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MSG_LEN`, default `` `MSG_LEN ``: message width in bits.
- `TIMEOUT_CYCLES`, default 1024: responder answer budget, in cycles.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: requester i holds its request until it sees `req_ack[i]`.
- `req_msg`, in, `NUM_REQ*MSG_LEN`: request i occupies slice `[i*MSG_LEN +: MSG_LEN]`.
- `req_ack`, out, `NUM_REQ`: one-cycle pulse when request i is latched.
- `rsp_valid`, out, `NUM_REQ`: response available for requester i; held until `rsp_ack[i]`.
- `rsp_msg`, out, `MSG_LEN`: response, valid while any `rsp_valid` bit is high.
- `rsp_ack`, in, `NUM_REQ`: requester i has consumed its response.
- `resp_req`, out, 1: to responder `resp_req_in`.
- `resp_msg`, out, `MSG_LEN`: to responder `auth_msg_resp_in`.
- `resp_ack`, out, 1: to responder `Ack_in`.
- `resp_done`, in, 1: from responder `resp_req_out`.
- `resp_rsp_msg`, in, `MSG_LEN`: from responder `auth_msg_resp_out`.

## Operation
FSM states are IDLE, GRANT, ISSUE, WAIT_RSP, DELIVER and RELEASE.

- **IDLE:**
  - If any `req_valid` bit is set, go to GRANT.
  - The round-robin search starts at `rr_ptr`, so the lowest index at or after `rr_ptr`, wrapping, wins.
- **GRANT:**
  - Register the grant index `g`.
  - Latch `req_msg` slice g into `msg_q`.
  - Pulse `req_ack[g]`.
  - Go to ISSUE.
- **ISSUE:**
  - Drive `resp_req=1` and `resp_msg=msg_q`.
  - Clear the timeout counter.
  - Go to WAIT_RSP.
- **WAIT_RSP:**
  - Hold `resp_req` and `resp_msg`.
  - On `resp_done=1`:
    - capture `resp_rsp_msg` into `rsp_q`;
    - pulse `resp_ack` for one cycle;
    - drop `resp_req`;
    - go to DELIVER.
  - On timeout, go to DELIVER (see Configuration).
- **DELIVER:**
  - Drive `rsp_valid[g]=1` and `rsp_msg=rsp_q`.
  - Wait for `rsp_ack[g]`; all other `rsp_ack` bits are ignored.
- **RELEASE:**
  - Clear `rsp_valid`.
  - Set `rr_ptr = (g+1) mod NUM_REQ`.
  - Go to IDLE.

Boundary rules:
- Only one request is outstanding at a time. New `req_valid` bits wait; they are never dropped.
- A requester dropping `req_valid` after its `req_ack` has no effect, because the message is already latched.
- `resp_done` seen outside WAIT_RSP is ignored. No `resp_ack` is sent for it.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.
- Reset mid-transaction:
  - go to IDLE;
  - set `rr_ptr=0`;
  - drive all outputs to 0;
  - abandon the pending grant without delivering a response.

## Timing
- Reset value of every output is 0: `req_ack`, `rsp_valid`, `rsp_msg`, `resp_req`, `resp_msg`, `resp_ack`.
- All outputs are registered on the rising edge.
- `req_valid` seen in IDLE at edge N gives:
  - `req_ack` high during cycle N+1;
  - `resp_req` high from N+2.
- `resp_done` sampled at edge M gives:
  - `resp_ack` high during cycle M+1;
  - `resp_req` low from M+1;
  - `rsp_valid` high from M+2.
- `rsp_ack` sampled at edge K gives `rsp_valid` low from K+1. The next grant can occur at K+2.
- Back-to-back minimum per transaction, with a one-cycle responder turnaround, is 7 cycles.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide. It increments only in WAIT_RSP and saturates; it never wraps.

## Configuration
- `RESP_ARB_TIMEOUT_EN` defined:
  - When the counter reaches `TIMEOUT_CYCLES` in WAIT_RSP, drop `resp_req` and load `rsp_q` with an ERROR message.
  - The ERROR message header is ProtocolVersion=1, MessageType=`` `ERR_MSG_TYPE ``, Param1=`` `ERR_CODE_BUSY ``, Param2=0, with a zero payload.
  - Then go to DELIVER. No `resp_ack` is issued.
  - A `resp_done` arriving in the same cycle as the timeout wins, and the real response is delivered.
- `RESP_ARB_TIMEOUT_EN` not defined:
  - No counter is instantiated.
  - WAIT_RSP waits indefinitely for `resp_done`.

## Structure
- `Parameters.v` holds:
  - the state encodings `ARB_IDLE` .. `ARB_RELEASE`, one-hot, with `` `SIZE_OF_STATES_ARB ``;
  - `` `ERR_MSG_TYPE ``;
  - `` `ERR_CODE_BUSY ``;
  - the reuse of `` `MSG_LEN ``, `` `SIZE_OF_HEADER_VARS `` and `` `SIZE_OF_HEADER_IN_BYTES ``.
- Sub-module `rr_arbiter`:
  - purely combinational;
  - inputs: `req` vector and `rr_ptr`;
  - outputs: `grant_idx` and `grant_any`.
- The FSM, message registers and timeout counter live in `resp_arbiter`.

## Test plan
- **Single request:** `NUM_REQ=4`, `req_valid=4'b0100` with a GET_DIGESTS message (0x01,0x81,0,0). Required response:
  - `req_ack=4'b0100` for one cycle;
  - `resp_msg` equals the message;
  - after `resp_done`, `rsp_valid=4'b0100` with `rsp_msg` equal to the responder output.
- **Round-robin fairness:** all four `req_valid` bits held high. Required response: grants in order 0,1,2,3,0, and no requester is granted twice before the others.
- **Timeout** (`RESP_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`): responder never asserts `resp_done`. Required response:
  - `resp_req` drops after 16 WAIT_RSP cycles;
  - `rsp_msg` header is 0x01, `` `ERR_MSG_TYPE ``, `` `ERR_CODE_BUSY ``, 0x00;
  - `resp_ack` stays 0.
- **Simultaneous completion:** `resp_done` arrives in the same cycle as the timeout. Required response: the real response is delivered and `resp_ack` pulses.
- **Reset in WAIT_RSP:** assert `reset` for one cycle. Required response:
  - all outputs 0 on the next edge;
  - `rr_ptr=0`;
  - a subsequent `req_valid=4'b0011` grants index 0 first.
- **Stray handshakes:** `resp_done` pulsed in IDLE, and `rsp_ack[1]` pulsed while delivering to requester 2. Required response: both are ignored, and the FSM state and outputs are unchanged.
